div_stream_ctrl: RTL and testbench
==================================

DIV_STREAM_CTRL -- requirements
Module: div_stream_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (integer plus fractional).
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO depth; a power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum cycles to wait for div_done after div_start.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have ports s_valid input 1, s_ready output 1, s_a input WIDTH signed, s_b input WIDTH signed: the operand stream.
REQ-007 SHALL have ports div_start output 1, div_a output WIDTH, div_b output WIDTH: drive to the divider.
REQ-008 SHALL have ports div_done, div_dbz, div_ovf (input, 1 each) and div_val (input, WIDTH): returned from the divider.
REQ-009 SHALL have ports m_valid output 1, m_ready input 1, m_val output WIDTH, m_dbz output 1, m_ovf output 1, m_tmo output 1: the result stream.
REQ-010 SHALL have port err_count, output, 8, a saturating count of results with dbz, ovf or tmo set.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-012 In IDLE: s_ready = 1 only when (FIFO occupancy) < DEPTH; at all other times s_ready = 0.
REQ-013 When s_valid and s_ready are both high in IDLE: SHALL register s_a to div_a and s_b to div_b, then go to ISSUE.
REQ-014 div_a and div_b SHALL stay stable from acceptance until the FSM returns to IDLE.
REQ-015 In ISSUE: div_start = 1 for exactly one cycle, timeout counter cleared, next state WAIT; div_start = 0 in every other state.
REQ-016 In WAIT with div_done = 1: SHALL push {div_val, div_dbz, div_ovf, tmo = 0} into the FIFO and go to IDLE.
REQ-017 The pushed value SHALL be forced to 0 when div_dbz or div_ovf is 1.
REQ-018 In WAIT: the counter increments each cycle without div_done.
REQ-019 When the counter reaches TIMEOUT-1 without div_done: SHALL push {val = 0, dbz = 0, ovf = 0, tmo = 1} and go to IDLE.
REQ-020 div_done in the same cycle as the timeout limit SHALL take priority; a normal result is pushed.
REQ-021 div_done while not in WAIT SHALL be ignored, with no push.
REQ-022 At most one operation SHALL be outstanding; the next s handshake can occur no earlier than the cycle after return to IDLE.
REQ-023 Latency: accept at edge N; div_start high in cycle N+1; div_done in cycle D gives a push at edge D and m_valid = 1 from cycle D+1.
REQ-024 FIFO: first-in first-out, registered outputs.
REQ-025 The FIFO head SHALL be presented on the m_val, m_dbz, m_ovf and m_tmo ports.
REQ-026 m_valid = (occupancy != 0); a pop occurs when m_valid and m_ready are both high.
REQ-027 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is log2(DEPTH)+1 bits.
REQ-028 A simultaneous push and pop SHALL leave occupancy unchanged and data ordered correctly, including when the FIFO is full.
REQ-029 m_val and the flag ports SHALL hold their values while m_valid = 1 and m_ready = 0.
REQ-030 err_count SHALL increment on each push with dbz, ovf or tmo set, and saturate at 255.

Reset
REQ-031 While rst = 1 at an edge: state = IDLE, FIFO emptied (pointers and occupancy 0), timeout counter 0.
REQ-032 The same reset SHALL drive div_start = 0, div_a = 0, div_b = 0, m_valid = 0, m_val = 0, m_dbz = m_ovf = m_tmo = 0 and err_count = 0.
REQ-033 Reset mid-operation SHALL discard the in-flight operation and all queued results.
REQ-034 A div_done arriving after reset SHALL be ignored under REQ-021.
REQ-035 s_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-036 Scenario: a=0x30 (3.0), b=0x20 (2.0), divider done after 12 cycles, m_ready=1 -> one result m_val=0x18, flags 0, m_valid one cycle after div_done.
REQ-037 Scenario: b=0x00, divider returns dbz=1 with val=0x55 -> m_val=0x00, m_dbz=1, err_count=1.
REQ-038 Scenario: div_done never asserted -> a result with m_tmo=1 and m_val=0 is pushed TIMEOUT cycles after div_start; the FSM then returns to IDLE.
REQ-039 Scenario: m_ready=0, five operands offered with DEPTH=4 -> four results queued and s_ready=0; raising m_ready drains the results in order, then the fifth is accepted.
REQ-040 Scenario: rst pulsed while in WAIT with two results queued -> m_valid=0 the next cycle; a later div_done produces no result.
REQ-041 Scenario: 300 consecutive ovf results -> err_count saturates at 255.

Source files
------------

// File: rtl/div_stream_ctrl.sv
// div_stream_ctrl
//   Front end for a multi-cycle fixed-point divider. Accepts one operand pair
//   at a time, launches the divider, waits for the result (or times out), and
//   queues {value, dbz, ovf, tmo} into a small result FIFO.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge where
//   valid and ready are both high. valid never depends on ready. Once m_valid
//   is high, m_val and the flag outputs stay unchanged until that transfer.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   s_valid/s_ready      operand stream handshake
//   s_a, s_b             dividend / divisor (signed, WIDTH bits)
//   div_start            one-cycle launch pulse to the divider
//   div_a, div_b         operands held stable for the whole operation
//   div_done             divider result strobe (only honoured in WAIT)
//   div_dbz, div_ovf     divider flags: divide-by-zero, overflow
//   div_val              divider quotient
//   m_valid/m_ready      result stream handshake
//   m_val, m_dbz,
//   m_ovf, m_tmo         FIFO head: value and flags (tmo = divider timed out)
//   err_count            saturating count of results with any flag set
//   dbg_state            current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
module div_stream_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_a,
  input  logic signed [WIDTH-1:0] s_b,
  output logic                    div_start,
  output logic [WIDTH-1:0]        div_a,
  output logic [WIDTH-1:0]        div_b,
  input  logic                    div_done,
  input  logic                    div_dbz,
  input  logic                    div_ovf,
  input  logic [WIDTH-1:0]        div_val,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_val,
  output logic                    m_dbz,
  output logic                    m_ovf,
  output logic                    m_tmo,
  output logic [7:0]              err_count,
  output logic [1:0]              dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             dbz;
    logic             ovf;
    logic             tmo;
  } entry_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [7:0]       err_q, err_d;

  logic             push;
  logic             pop;
  entry_t           push_e;

  // Control FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    push    = 1'b0;
    push_e  = '0;
    // Only IDLE accepts, so at most one operation is ever in flight.
    s_ready = (state_q == IDLE) && (count_q < FULL_CNT);
    unique case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          div_a_d = s_a;
          div_b_d = s_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // div_done wins over a timeout reached in the same cycle.
        if (div_done) begin
          push       = 1'b1;
          push_e.val = (div_dbz || div_ovf) ? '0 : div_val;
          push_e.dbz = div_dbz;
          push_e.ovf = div_ovf;
          state_d    = IDLE;
        end else if (cnt_q == TO_LAST) begin
          push       = 1'b1;
          push_e.tmo = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result FIFO. A push can never land on a full FIFO: acceptance required a
  // free slot and nothing else pushes while the operation is outstanding.
  always_comb begin
    pop      = (count_q != '0) && m_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_e;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      if ((push_e.dbz || push_e.ovf || push_e.tmo) && (err_q != 8'hFF))
        err_d = err_q + 8'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_a_q  <= '0;
      div_b_q  <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign div_start = (state_q == ISSUE);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign m_valid   = (count_q != '0);
  assign m_val     = mem_q[rd_ptr_q].val;
  assign m_dbz     = mem_q[rd_ptr_q].dbz;
  assign m_ovf     = mem_q[rd_ptr_q].ovf;
  assign m_tmo     = mem_q[rd_ptr_q].tmo;
  assign err_count = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_stream_ctrl.sv
// tb_div_stream_ctrl
//   Directed bench for div_stream_ctrl (WIDTH=8, DEPTH=4, TIMEOUT=64).
//   The bench plays the divider itself; expected values are hand-computed.
module tb_div_stream_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_done;
  logic             div_dbz;
  logic             div_ovf;
  logic [WIDTH-1:0] div_val;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_val;
  logic             m_dbz;
  logic             m_ovf;
  logic             m_tmo;
  logic [7:0]       err_count;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  div_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_dbz(div_dbz), .div_ovf(div_ovf), .div_val(div_val),
    .m_valid(m_valid), .m_ready(m_ready), .m_val(m_val),
    .m_dbz(m_dbz), .m_ovf(m_ovf), .m_tmo(m_tmo),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: hand over operands, then answer as the divider with
  // div_done after `delay` WAIT cycles. Returns in the cycle after the push.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] v,
                       input logic dbz, input logic ovf, input int delay);
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    for (int k = 0; k < 200 && !s_ready; k++) tick();
    check("op_s_ready_wait", s_ready, 1);
    tick();
    s_valid = 1'b0;
    tick();
    repeat (delay) tick();
    div_done = 1'b1;
    div_val  = v;
    div_dbz  = dbz;
    div_ovf  = ovf;
    tick();
    div_done = 1'b0;
    div_dbz  = 1'b0;
    div_ovf  = 1'b0;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0;
    div_done = 1'b0; div_dbz = 1'b0; div_ovf = 1'b0; div_val = '0;
    m_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_m_valid", m_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_m_val", m_val, 0);
    check("rst_m_flags", {m_dbz, m_ovf, m_tmo}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    check("s_ready_after_rst", s_ready, 1);

    // div_done while IDLE is ignored
    div_done = 1'b1; div_val = 8'h99;
    tick();
    div_done = 1'b0;
    check("idle_done_ignored", m_valid, 0);

    // 3.0 / 2.0 = 1.5, divider done 12 cycles after launch
    s_valid = 1'b1; s_a = 8'h30; s_b = 8'h20;
    tick();
    s_valid = 1'b0;
    check("s36_div_start", div_start, 1);
    check("s36_div_a", div_a, 8'h30);
    check("s36_div_b", div_b, 8'h20);
    check("s36_busy_s_ready", s_ready, 0);
    check("s36_state_issue", dbg_state, 1);
    tick();
    check("s36_start_pulse_end", div_start, 0);
    check("s36_state_wait", dbg_state, 2);
    repeat (11) tick();
    check("s36_no_early_valid", m_valid, 0);
    check("s36_div_a_stable", div_a, 8'h30);
    div_done = 1'b1; div_val = 8'h18;
    tick();
    div_done = 1'b0;
    check("s36_m_valid", m_valid, 1);
    check("s36_m_val", m_val, 8'h18);
    check("s36_flags", {m_dbz, m_ovf, m_tmo}, 0);
    check("s36_err_count", err_count, 0);
    check("s36_back_idle", dbg_state, 0);
    pop_one();
    check("s36_popped", m_valid, 0);

    // Divide by zero: value forced to 0
    do_op(8'h30, 8'h00, 8'h55, 1'b1, 1'b0, 0);
    check("s37_m_valid", m_valid, 1);
    check("s37_m_val", m_val, 0);
    check("s37_m_dbz", m_dbz, 1);
    check("s37_err_count", err_count, 1);
    pop_one();

    // Timeout: no div_done at all
    s_valid = 1'b1; s_a = 8'h10; s_b = 8'h20;
    tick();
    s_valid = 1'b0;
    repeat (TIMEOUT) tick();
    check("s38_no_early_tmo", m_valid, 0);
    check("s38_still_wait", dbg_state, 2);
    tick();
    check("s38_m_valid", m_valid, 1);
    check("s38_m_tmo", m_tmo, 1);
    check("s38_m_val", m_val, 0);
    check("s38_dbz_ovf", {m_dbz, m_ovf}, 0);
    check("s38_err_count", err_count, 2);
    check("s38_idle", dbg_state, 0);
    pop_one();

    // div_done on the last timeout cycle wins
    s_valid = 1'b1; s_a = 8'h40; s_b = 8'h20;
    tick();
    s_valid = 1'b0;
    repeat (TIMEOUT) tick();
    div_done = 1'b1; div_val = 8'h42;
    tick();
    div_done = 1'b0;
    check("s20_m_tmo", m_tmo, 0);
    check("s20_m_val", m_val, 8'h42);
    check("s20_err_count", err_count, 2);
    pop_one();

    // Fill the FIFO with m_ready low, then a fifth operand waits
    for (int i = 0; i < DEPTH; i++) begin
      do_op(8'h08, 8'h01, 8'(i + 1), 1'b0, 1'b0, 1);
    end
    check("s39_full_valid", m_valid, 1);
    check("s39_full_s_ready", s_ready, 0);
    s_valid = 1'b1; s_a = 8'h50; s_b = 8'h10;
    repeat (3) tick();
    check("s39_blocked_s_ready", s_ready, 0);
    check("s39_blocked_idle", dbg_state, 0);
    check("s39_no_start", div_start, 0);
    check("s39_head_hold", m_val, 8'h01);
    m_ready = 1'b1;
    check("s39_drain_1", m_val, 8'h01);
    tick();
    check("s39_drain_2", m_val, 8'h02);
    check("s39_slot_free", s_ready, 1);
    tick();
    s_valid = 1'b0;
    check("s39_fifth_start", div_start, 1);
    check("s39_fifth_a", div_a, 8'h50);
    check("s39_drain_3", m_val, 8'h03);
    tick();
    check("s39_drain_4", m_val, 8'h04);
    tick();
    check("s39_drained", m_valid, 0);
    m_ready = 1'b0;
    div_done = 1'b1; div_val = 8'h05;
    tick();
    div_done = 1'b0;
    check("s39_fifth_valid", m_valid, 1);
    check("s39_fifth_val", m_val, 8'h05);
    pop_one();

    // Reset while WAIT with two results queued
    do_op(8'h08, 8'h01, 8'h61, 1'b0, 1'b0, 0);
    do_op(8'h08, 8'h01, 8'h62, 1'b0, 1'b0, 0);
    s_valid = 1'b1; s_a = 8'h22; s_b = 8'h11;
    tick();
    s_valid = 1'b0;
    tick();
    check("s40_pre_valid", m_valid, 1);
    check("s40_pre_wait", dbg_state, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s40_m_valid", m_valid, 0);
    check("s40_state", dbg_state, 0);
    check("s40_div_a", div_a, 0);
    check("s40_m_val", m_val, 0);
    check("s40_err_count", err_count, 0);
    check("s40_s_ready", s_ready, 1);
    div_done = 1'b1; div_val = 8'h77;
    tick();
    div_done = 1'b0;
    check("s40_late_done_ignored", m_valid, 0);

    // 300 overflow results: err_count saturates
    m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do_op(8'h7F, 8'h01, 8'h33, 1'b0, 1'b1, 0);
      if (i == 0) begin
        check("s41_first_m_ovf", m_ovf, 1);
        check("s41_first_m_val", m_val, 0);
        check("s41_first_err", err_count, 1);
      end
      if (i == 254) check("s41_err_255", err_count, 255);
    end
    check("s41_err_saturated", err_count, 255);
    m_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
